// File: rtl/fwd_sel_pipe.sv
// N-way operand-forwarding selector with registered output and a two-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining FWD_SEL_PIPE_SELERR_EN.
module fwd_sel_pipe #(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned NUM_IN = 3,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              level,
    output logic                    sel_err
);

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] last_sel_q, last_sel_d;
    logic             in_ready_q, in_ready_d;
    logic [1:0]       level_q, level_d;

    logic             accept_c;
    logic             consume_c;
    logic             in_range_c;
    logic [WIDTH-1:0] cand_c;

    assign accept_c  = in_valid & in_ready_q;
    assign consume_c = main_valid_q & out_ready;

    // Candidate mux; out-of-range selects fall back to the last accepted in-range value.
    always_comb begin
        cand_c     = last_sel_q;
        in_range_c = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                cand_c     = in_data[i*WIDTH +: WIDTH];
                in_range_c = 1'b1;
            end
        end
    end

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        last_sel_d   = last_sel_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume_c) begin
                main_valid_d = skid_valid_q;
                if (skid_valid_q) begin
                    main_data_d = skid_data_q;
                end
                skid_valid_d = 1'b0;
            end
            // Accept only happens with the skid slot empty, since in_ready tracks it.
            if (accept_c) begin
                if (!main_valid_q || consume_c) begin
                    main_data_d  = cand_c;
                    main_valid_d = 1'b1;
                end else begin
                    skid_data_d  = cand_c;
                    skid_valid_d = 1'b1;
                end
                if (in_range_c) begin
                    last_sel_d = cand_c;
                end
            end
        end
        in_ready_d = ~skid_valid_d;
        level_d    = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            last_sel_q   <= '0;
            in_ready_q   <= 1'b1;
            level_q      <= 2'd0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            last_sel_q   <= last_sel_d;
            in_ready_q   <= in_ready_d;
            level_q      <= level_d;
        end
    end

`ifdef FWD_SEL_PIPE_SELERR_EN
    logic sel_err_q;

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (accept_c && !in_range_c) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

    assign out_data  = main_data_q;
    assign out_valid = main_valid_q;
    assign in_ready  = in_ready_q;
    assign level     = level_q;

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Bench for fwd_sel_pipe: directed vector table on a 32x3 instance, random run on 32x3 and 8x8
// instances against a depth-2 FIFO reference model.
module tb_fwd_sel_pipe;

`ifdef FWD_SEL_PIPE_SELERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [95:0] in_data0;
    logic [1:0]  sel0;
    logic        iv0, ir0, fl0, ov0, or0, se0;
    logic [31:0] od0;
    logic [1:0]  lv0;

    logic [63:0] in_data1;
    logic [2:0]  sel1;
    logic        iv1, ir1, fl1, ov1, or1, se1;
    logic [7:0]  od1;
    logic [1:0]  lv1;

    fwd_sel_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data0), .sel(sel0), .in_valid(iv0),
        .in_ready(ir0), .flush(fl0), .out_data(od0), .out_valid(ov0), .out_ready(or0),
        .level(lv0), .sel_err(se0)
    );

    fwd_sel_pipe #(.WIDTH(8), .NUM_IN(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .sel(sel1), .in_valid(iv1),
        .in_ready(ir1), .flush(fl1), .out_data(od1), .out_valid(ov1), .out_ready(or1),
        .level(lv1), .sel_err(se1)
    );

    typedef struct {
        bit          iv;
        logic [1:0]  sel;
        bit          ordy;
        bit          fl;
        logic [31:0] c0, c1, c2;
        bit          eov;
        logic [31:0] edata;
        logic [1:0]  elvl;
        bit          eir;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl[NVEC];

    // Reference model: an ordered buffer of at most two entries per instance.
    logic [63:0] mbuf[2][2];
    int          mcnt[2];
    logic [63:0] mlast[2];
    bit          merr[2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input bit iv, input int sel, input bit o, input bit f,
                                input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                                input bit eov, input logic [31:0] ed, input int el, input bit eir);
        vec_t v;
        v.iv = iv; v.sel = 2'(sel); v.ordy = o; v.fl = f;
        v.c0 = c0; v.c1 = c1; v.c2 = c2;
        v.eov = eov; v.edata = ed; v.elvl = 2'(el); v.eir = eir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d]  = 0;
            mlast[d] = '0;
            merr[d]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int d, input bit iv, input bit inr, input logic [63:0] v,
                              input bit ordy, input bit fl);
        bit          acc, cons;
        logic [63:0] val;
        acc  = iv && (mcnt[d] < 2);
        cons = (mcnt[d] > 0) && ordy;
        val  = inr ? v : mlast[d];
        if (acc && !inr && ERR_EN) merr[d] = 1'b1;
        if (fl) begin
            mcnt[d] = 0;
        end else begin
            if (cons) begin
                mbuf[d][0] = mbuf[d][1];
                mcnt[d]--;
            end
            if (acc) begin
                mbuf[d][mcnt[d]] = val;
                mcnt[d]++;
                if (inr) mlast[d] = val;
            end
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then settle.
    task automatic tick();
        bit          inr0;
        logic [63:0] c0, c1;
        @(posedge clk);
        if (rst_n) begin
            inr0 = (sel0 < 2'd3);
            c0   = 64'(in_data0 >> (32 * int'(sel0))) & 64'hFFFF_FFFF;
            c1   = 64'(in_data1 >> (8 * int'(sel1))) & 64'hFF;
            model_edge(0, iv0, inr0, c0, or0, fl0);
            model_edge(1, iv1, 1'b1, c1, or1, fl1);
        end
        #1;
    endtask

    task automatic check_dut(input int d);
        logic [63:0] od;
        logic        ov, ir, se;
        logic [1:0]  lv;
        if (d == 0) begin
            od = 64'(od0); ov = ov0; ir = ir0; se = se0; lv = lv0;
        end else begin
            od = 64'(od1); ov = ov1; ir = ir1; se = se1; lv = lv1;
        end
        chk($sformatf("dut%0d out_valid", d), 64'(ov), 64'(mcnt[d] > 0));
        chk($sformatf("dut%0d level", d), 64'(lv), 64'(mcnt[d]));
        chk($sformatf("dut%0d in_ready", d), 64'(ir), 64'(mcnt[d] < 2));
        chk($sformatf("dut%0d sel_err", d), 64'(se), 64'(merr[d]));
        if (mcnt[d] > 0) chk($sformatf("dut%0d out_data", d), od, mbuf[d][0]);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " out_data0"}, 64'(od0), 64'h0);
        chk({tag, " out_valid0"}, 64'(ov0), 64'h0);
        chk({tag, " in_ready0"}, 64'(ir0), 64'h1);
        chk({tag, " level0"}, 64'(lv0), 64'h0);
        chk({tag, " sel_err0"}, 64'(se0), 64'h0);
        chk({tag, " out_data1"}, 64'(od1), 64'h0);
        chk({tag, " out_valid1"}, 64'(ov1), 64'h0);
        chk({tag, " in_ready1"}, 64'(ir1), 64'h1);
        chk({tag, " level1"}, 64'(lv1), 64'h0);
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 0, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 32'h11111111, 1, 1'b1);
        tbl[1]  = mk(1'b1, 1, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 32'h22222222, 1, 1'b1);
        tbl[2]  = mk(1'b1, 2, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 32'h33333333, 1, 1'b1);
        tbl[3]  = mk(1'b1, 1, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 32'h22222222, 1, 1'b1);
        tbl[4]  = mk(1'b1, 3, 1'b1, 1'b0, 32'h11111111, 32'h00000099, 32'h33333333, 1'b1, 32'h22222222, 1, 1'b1);
        tbl[5]  = mk(1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b1);
        tbl[6]  = mk(1'b1, 0, 1'b0, 1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b1, 32'hAAAA0001, 1, 1'b1);
        tbl[7]  = mk(1'b1, 1, 1'b0, 1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b1, 32'hAAAA0001, 2, 1'b0);
        tbl[8]  = mk(1'b1, 2, 1'b0, 1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b1, 32'hAAAA0001, 2, 1'b0);
        tbl[9]  = mk(1'b0, 0, 1'b1, 1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b1, 32'hBBBB0002, 1, 1'b1);
        tbl[10] = mk(1'b0, 0, 1'b1, 1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b0, 32'h0, 0, 1'b1);
        tbl[11] = mk(1'b1, 2, 1'b1, 1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b1, 32'hCCCC0003, 1, 1'b1);
        tbl[12] = mk(1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b1);
        tbl[13] = mk(1'b1, 0, 1'b0, 1'b0, 32'h5, 32'h6, 32'h7, 1'b1, 32'h5, 1, 1'b1);
        tbl[14] = mk(1'b1, 1, 1'b0, 1'b0, 32'h5, 32'h6, 32'h7, 1'b1, 32'h5, 2, 1'b0);
        tbl[15] = mk(1'b1, 2, 1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 1'b0, 32'h0, 0, 1'b1);
        tbl[16] = mk(1'b1, 3, 1'b0, 1'b0, 32'h5, 32'h6, 32'h7, 1'b1, 32'h6, 1, 1'b1);
        tbl[17] = mk(1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b1);
        tbl[18] = mk(1'b1, 0, 1'b1, 1'b0, 32'h8, 32'h9, 32'hA, 1'b1, 32'h8, 1, 1'b1);
        tbl[19] = mk(1'b1, 1, 1'b1, 1'b1, 32'h8, 32'hAB, 32'hA, 1'b0, 32'h0, 0, 1'b1);
        tbl[20] = mk(1'b1, 3, 1'b1, 1'b0, 32'h8, 32'hAB, 32'hA, 1'b1, 32'h8, 1, 1'b1);
        tbl[21] = mk(1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b1);

        rst_n = 1'b0;
        in_data0 = '0; sel0 = '0; iv0 = 1'b0; fl0 = 1'b0; or0 = 1'b0;
        in_data1 = '0; sel1 = '0; iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;

        // Directed table on the 32-bit, three-input instance.
        for (int i = 0; i < NVEC; i++) begin
            iv0 = tbl[i].iv; sel0 = tbl[i].sel; or0 = tbl[i].ordy; fl0 = tbl[i].fl;
            in_data0 = {tbl[i].c2, tbl[i].c1, tbl[i].c0};
            tick();
            chk($sformatf("vec%0d out_valid", i), 64'(ov0), 64'(tbl[i].eov));
            chk($sformatf("vec%0d level", i), 64'(lv0), 64'(tbl[i].elvl));
            chk($sformatf("vec%0d in_ready", i), 64'(ir0), 64'(tbl[i].eir));
            if (tbl[i].eov) chk($sformatf("vec%0d out_data", i), 64'(od0), 64'(tbl[i].edata));
            check_dut(0);
        end
        iv0 = 1'b0; fl0 = 1'b0;

        // Top candidate of the eight-input instance comes from the highest byte.
        in_data1 = 64'h0123_4567_89AB_CDEF; sel1 = 3'd7; iv1 = 1'b1; or1 = 1'b1;
        tick();
        chk("sel7 out_data", 64'(od1), 64'h01);
        check_dut(1);
        iv1 = 1'b0;
        tick();
        check_dut(1);

        // Asynchronous reset in the middle of a cycle with both entries occupied.
        iv0 = 1'b1; sel0 = 2'd0; or0 = 1'b0; in_data0 = {32'h3, 32'h2, 32'h1};
        iv1 = 1'b1; sel1 = 3'd2; or1 = 1'b0; in_data1 = 64'hFFEE_DDCC_BBAA_9988;
        tick();
        tick();
        check_dut(0);
        check_dut(1);
        iv0 = 1'b0; iv1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            iv0 = 1'($urandom_range(0, 3) != 0);
            sel0 = 2'($urandom_range(0, 3));
            or0 = 1'($urandom_range(0, 2) != 0);
            fl0 = 1'($urandom_range(0, 15) == 0);
            in_data0 = {$urandom, $urandom, $urandom};
            iv1 = 1'($urandom_range(0, 3) != 0);
            sel1 = 3'($urandom_range(0, 7));
            or1 = 1'($urandom_range(0, 1));
            fl1 = 1'($urandom_range(0, 31) == 0);
            in_data1 = {$urandom, $urandom};
            tick();
            check_dut(0);
            check_dut(1);
        end

        iv0 = 1'b0; fl0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b1;
        repeat (3) begin
            tick();
            check_dut(0);
            check_dut(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
